// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single CHIP-8 program/sprite memory between the draw, execute
// and fetch readers and the host/execute writers, with draw lock bursts and fetch anti-starvation.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  draw_req,
  input  logic                  draw_lock,
  input  logic [ADDR_WIDTH-1:0] draw_addr,
  output logic                  draw_gnt,
  output logic                  draw_vld,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic                  exec_rd_gnt,
  output logic                  exec_rd_vld,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_waddr,
  input  logic [DATA_WIDTH-1:0] host_d,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_waddr,
  input  logic [DATA_WIDTH-1:0] exec_d,
  output logic                  exec_wgnt,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_d,
  output logic                  locked
);

  localparam int unsigned      CNT_W      = 8;
  localparam logic [CNT_W-1:0] STARVE_SAT = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {OWN_DRAW, OWN_EXEC, OWN_FETCH, OWN_NONE} owner_t;
  typedef enum logic {LK_OPEN, LK_HELD} lock_t;

  lock_t                 lock_q, lock_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  owner_t                cand, sel;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic                  hazard;
  logic                  pipe_vld [RD_LAT];
  owner_t                pipe_own [RD_LAT];

  // Pick one read candidate, then drop it if it would read an address being written now.
  always_comb begin : arbitrate
    cand      = OWN_NONE;
    cand_addr = '0;
    if (lock_q == LK_HELD) begin
      if (draw_req) cand = OWN_DRAW;
    end else if (starve_q == STARVE_SAT && fetch_req) begin
      cand = OWN_FETCH;
    end else if (draw_req) begin
      cand = OWN_DRAW;
    end else if (exec_rd_req) begin
      cand = OWN_EXEC;
    end else if (fetch_req) begin
      cand = OWN_FETCH;
    end
    case (cand)
      OWN_DRAW:  cand_addr = draw_addr;
      OWN_EXEC:  cand_addr = exec_rd_addr;
      OWN_FETCH: cand_addr = fetch_addr;
      default:   cand_addr = '0;
    endcase
    hazard = mem_we && (cand != OWN_NONE) && (cand_addr == mem_waddr);
    sel    = (!rst_n || hazard) ? OWN_NONE : cand;
  end

  always_comb begin : next_state
    lock_d   = lock_q;
    starve_d = '0;
    if (sel == OWN_DRAW) begin
      lock_d = draw_lock ? LK_HELD : LK_OPEN;
    end else if (lock_q == LK_HELD && !draw_req) begin
      lock_d = LK_OPEN;
    end
    if (fetch_req && sel != OWN_FETCH) begin
      starve_d = (starve_q >= STARVE_SAT) ? STARVE_SAT : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      lock_q   <= LK_OPEN;
      starve_q <= '0;
    end else begin
      lock_q   <= lock_d;
      starve_q <= starve_d;
    end
  end

  // Owner tag travels alongside the read so the data-valid strobe reaches only its requester.
  always_ff @(posedge clk) begin : return_pipe
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_own[i] <= OWN_NONE;
      end
    end else begin
      pipe_vld[0] <= (sel != OWN_NONE);
      pipe_own[0] <= sel;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin : write_reg
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_d     <= '0;
    end else begin
      mem_we <= host_we | exec_wgnt;
      if (host_we) begin
        mem_waddr <= host_waddr;
        mem_d     <= host_d;
      end else if (exec_wgnt) begin
        mem_waddr <= exec_waddr;
        mem_d     <= exec_d;
      end
    end
  end

  assign draw_gnt    = (sel == OWN_DRAW);
  assign exec_rd_gnt = (sel == OWN_EXEC);
  assign fetch_gnt   = (sel == OWN_FETCH);
  assign mem_re      = (sel != OWN_NONE);
  assign mem_raddr   = mem_re ? cand_addr : '0;
  assign locked      = (lock_q == LK_HELD);
  assign exec_wgnt   = rst_n & exec_we & ~host_we;
  assign rd_data     = mem_q;
  assign draw_vld    = pipe_vld[RD_LAT-1] && (pipe_own[RD_LAT-1] == OWN_DRAW);
  assign exec_rd_vld = pipe_vld[RD_LAT-1] && (pipe_own[RD_LAT-1] == OWN_EXEC);
  assign fetch_vld   = pipe_vld[RD_LAT-1] && (pipe_own[RD_LAT-1] == OWN_FETCH);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus for mem_arbiter, checked each cycle against
// a transaction-level model (owner codes 0 draw, 1 exec, 2 fetch, -1 none).
module tb_mem_arbiter;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int LAT  = 3;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          draw_req, draw_lock, draw_gnt, draw_vld;
  logic [AW-1:0] draw_addr;
  logic          exec_rd_req, exec_rd_gnt, exec_rd_vld;
  logic [AW-1:0] exec_rd_addr;
  logic          fetch_req, fetch_gnt, fetch_vld;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] rd_data;
  logic          host_we, exec_we, exec_wgnt;
  logic [AW-1:0] host_waddr, exec_waddr;
  logic [DW-1:0] host_d, exec_d;
  logic          mem_re, mem_we, locked;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_q, mem_d;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .draw_req(draw_req), .draw_lock(draw_lock), .draw_addr(draw_addr),
    .draw_gnt(draw_gnt), .draw_vld(draw_vld),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_rd_gnt(exec_rd_gnt), .exec_rd_vld(exec_rd_vld),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_vld(fetch_vld), .rd_data(rd_data),
    .host_we(host_we), .host_waddr(host_waddr), .host_d(host_d),
    .exec_we(exec_we), .exec_waddr(exec_waddr), .exec_d(exec_d), .exec_wgnt(exec_wgnt),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_q(mem_q),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_d(mem_d), .locked(locked)
  );

  function automatic logic [DW-1:0] init_val(int a);
    return DW'((a * 37 + 11) ^ (a >> 4));
  endfunction

  // Behavioural memory with LAT-cycle read latency, driven by the DUT's memory port
  logic [DW-1:0] tb_mem [4096];
  logic [DW-1:0] qpipe [LAT];
  logic          load_mem;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= init_val(i);
    end else if (mem_we) begin
      tb_mem[mem_waddr] <= mem_d;
    end
    if (mem_re) qpipe[0] <= tb_mem[mem_raddr];
    for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
  end
  assign mem_q = qpipe[LAT-1];

  // Reference model state
  typedef struct { int due; int owner; logic [DW-1:0] data; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] ref_mem [4096];
  bit            m_locked;
  int            m_starve;
  bit            m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_d;
  int            cyc, n_cmp, n_fail;

  logic [2:0]    s_gv, s_vv;
  logic [AW-1:0] s_raddr, s_waddr;
  logic [DW-1:0] s_rdata, s_wd;
  logic          s_wgnt, s_we, s_locked;

  function automatic logic [2:0] onehot(int o);
    return (o >= 0) ? 3'(32'd1 << o) : 3'b000;
  endfunction

  function automatic logic [AW-1:0] addr_of(int o);
    case (o)
      0:       return draw_addr;
      1:       return exec_rd_addr;
      default: return fetch_addr;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic tick();
    int            want_g, want_v;
    logic [AW-1:0] a;
    @(negedge clk);
    want_g = -1;
    if (m_locked) begin
      if (draw_req) want_g = 0;
    end else if (m_starve == SMAX && fetch_req) want_g = 2;
    else if (draw_req) want_g = 0;
    else if (exec_rd_req) want_g = 1;
    else if (fetch_req) want_g = 2;
    a = (want_g >= 0) ? addr_of(want_g) : '0;
    if (!rst_n || (want_g >= 0 && m_we && a == m_waddr)) begin
      want_g = -1;
      a      = '0;
    end
    want_v = (rq.size() > 0 && rq[0].due == cyc) ? rq[0].owner : -1;

    chk("rd_gnt", 32'({fetch_gnt, exec_rd_gnt, draw_gnt}), 32'(onehot(want_g)));
    chk("mem_re", 32'(mem_re), 32'(want_g >= 0));
    chk("mem_raddr", 32'(mem_raddr), 32'(a));
    chk("exec_wgnt", 32'(exec_wgnt), 32'(rst_n & exec_we & ~host_we));
    chk("rd_vld", 32'({fetch_vld, exec_rd_vld, draw_vld}), 32'(onehot(want_v)));
    if (want_v >= 0) chk("rd_data", 32'(rd_data), 32'(rq[0].data));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(m_waddr));
      chk("mem_d", 32'(mem_d), 32'(m_d));
    end

    s_gv = {fetch_gnt, exec_rd_gnt, draw_gnt};
    s_vv = {fetch_vld, exec_rd_vld, draw_vld};
    s_raddr = mem_raddr;  s_rdata = rd_data;  s_wgnt = exec_wgnt;
    s_we = mem_we;  s_waddr = mem_waddr;  s_wd = mem_d;  s_locked = locked;

    @(posedge clk);
    if (want_v >= 0) void'(rq.pop_front());
    if (want_g >= 0) rq.push_back('{due: cyc + LAT, owner: want_g, data: ref_mem[a]});
    if (m_we) ref_mem[m_waddr] = m_d;
    if (!rst_n) begin
      rq.delete();
      m_locked = 1'b0;  m_starve = 0;
      m_we = 1'b0;  m_waddr = '0;  m_d = '0;
    end else begin
      if (want_g == 0) m_locked = draw_lock;
      else if (m_locked && !draw_req) m_locked = 1'b0;
      if (fetch_req && want_g != 2) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
      if (host_we) begin
        m_we = 1'b1;  m_waddr = host_waddr;  m_d = host_d;
      end else if (exec_we) begin
        m_we = 1'b1;  m_waddr = exec_waddr;  m_d = exec_d;
      end else begin
        m_we = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    draw_req = 1'b0;  draw_lock = 1'b0;  draw_addr = '0;
    exec_rd_req = 1'b0;  exec_rd_addr = '0;
    fetch_req = 1'b0;  fetch_addr = '0;
    host_we = 1'b0;  host_waddr = '0;  host_d = '0;
    exec_we = 1'b0;  exec_waddr = '0;  exec_d = '0;
  endtask

  initial begin
    int         waits, waits2;
    bit         got;
    int         n_draw;
    logic [2:0] order [3];
    logic [2:0] vld_or;
    logic       lock_or;
    bit         ex_pend;

    n_cmp = 0;  n_fail = 0;  cyc = 0;
    m_locked = 1'b0;  m_starve = 0;  m_we = 1'b0;  m_waddr = '0;  m_d = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    idle();
    rst_n = 1'b0;  load_mem = 1'b1;
    @(posedge clk);
    #1;
    load_mem = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_gnt", 32'(s_gv), 32'd0);
    chk("rst_vld", 32'(s_vv), 32'd0);
    chk("rst_we_lock", 32'({s_we, s_locked, s_wgnt}), 32'd0);
    chk("rst_addrs", 32'({s_raddr, s_waddr, s_wd}), 32'd0);

    // Single uncontended fetch
    rst_n = 1'b1;
    fetch_req = 1'b1;  fetch_addr = 12'h200;
    tick();
    chk("f1_gnt", 32'(s_gv), 32'b100);
    chk("f1_raddr", 32'(s_raddr), 32'h200);
    fetch_req = 1'b0;
    tick();  tick();  tick();
    chk("f1_vld", 32'(s_vv), 32'b100);
    chk("f1_data", 32'(s_rdata), 32'(init_val(12'h200)));

    // Three simultaneous requesters, each dropping its request once granted
    draw_req = 1'b1;  draw_addr = 12'h210;
    exec_rd_req = 1'b1;  exec_rd_addr = 12'h220;
    fetch_req = 1'b1;  fetch_addr = 12'h230;
    for (int k = 0; k < 3; k++) begin
      tick();
      order[k] = s_gv;
      if (s_gv[0]) draw_req = 1'b0;
      if (s_gv[1]) exec_rd_req = 1'b0;
      if (s_gv[2]) fetch_req = 1'b0;
    end
    chk("ord_draw", 32'(order[0]), 32'b001);
    chk("ord_exec", 32'(order[1]), 32'b010);
    chk("ord_fetch", 32'(order[2]), 32'b100);
    tick();  chk("ord_vld0", 32'(s_vv), 32'b001);
    tick();  chk("ord_vld1", 32'(s_vv), 32'b010);
    tick();  chk("ord_vld2", 32'(s_vv), 32'b100);

    // Five-beat locked draw burst against competing exec and fetch
    n_draw = 0;
    draw_req = 1'b1;  exec_rd_req = 1'b1;  exec_rd_addr = 12'h260;
    fetch_req = 1'b1;  fetch_addr = 12'h270;
    for (int b = 0; b < 5; b++) begin
      draw_addr = 12'h240 + AW'(b);
      draw_lock = (b < 4);
      tick();
      if (s_gv == 3'b001) n_draw++;
    end
    chk("burst_beats", 32'(n_draw), 32'd5);
    draw_req = 1'b0;  draw_lock = 1'b0;
    tick();
    chk("burst_next_exec", 32'(s_gv), 32'b010);
    exec_rd_req = 1'b0;
    tick();
    fetch_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // Fetch starvation against continuous exec reads
    exec_rd_req = 1'b1;  exec_rd_addr = 12'h280;
    fetch_req = 1'b1;  fetch_addr = 12'h290;
    waits = 0;  got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      if (s_gv == 3'b100) got = 1'b1; else waits++;
    end
    chk("starve_wait", 32'(waits), 32'(SMAX));
    waits2 = 0;  got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      if (s_gv == 3'b100) got = 1'b1; else waits2++;
    end
    chk("starve_rewait", 32'(waits2), 32'(SMAX));
    idle();
    for (int k = 0; k < 4; k++) tick();

    // Same-address host/exec write collision, then a fetch of that address
    host_we = 1'b1;  host_waddr = 12'h300;  host_d = 8'hAA;
    exec_we = 1'b1;  exec_waddr = 12'h300;  exec_d = 8'h55;
    tick();
    chk("col_wgnt", 32'(s_wgnt), 32'd0);
    idle();
    fetch_req = 1'b1;  fetch_addr = 12'h300;
    tick();
    chk("col_we", 32'(s_we), 32'd1);
    chk("col_wdata", 32'({s_waddr, s_wd}), 32'h300AA);
    chk("col_stall", 32'(s_gv), 32'd0);
    tick();
    chk("col_retry", 32'(s_gv), 32'b100);
    fetch_req = 1'b0;
    tick();  tick();  tick();
    chk("col_data", 32'({s_vv, s_rdata}), 32'h4AA);

    // Reset while two locked draw reads are in flight
    draw_req = 1'b1;  draw_lock = 1'b1;  draw_addr = 12'h250;
    tick();
    tick();
    chk("mid_locked", 32'(s_locked), 32'd1);
    rst_n = 1'b0;  draw_req = 1'b0;  draw_lock = 1'b0;
    tick();
    rst_n = 1'b1;
    vld_or = '0;  lock_or = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      vld_or |= s_vv;
      lock_or |= s_locked;
    end
    chk("mid_no_vld", 32'(vld_or), 32'd0);
    chk("mid_unlock", 32'(lock_or), 32'd0);
    chk("mid_quiet", 32'({s_gv, s_we}), 32'd0);

    // Random traffic on a narrow address window to provoke hazards and collisions
    ex_pend = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      draw_req     = ($urandom_range(0, 2) == 0);
      draw_lock    = ($urandom_range(0, 1) == 0);
      draw_addr    = 12'h300 + AW'($urandom_range(0, 7));
      exec_rd_req  = ($urandom_range(0, 3) != 0);
      exec_rd_addr = 12'h300 + AW'($urandom_range(0, 7));
      fetch_req    = ($urandom_range(0, 1) == 0);
      fetch_addr   = 12'h300 + AW'($urandom_range(0, 7));
      host_we      = ($urandom_range(0, 4) == 0);
      host_waddr   = 12'h300 + AW'($urandom_range(0, 7));
      host_d       = DW'($urandom);
      if (!ex_pend) begin
        exec_we    = ($urandom_range(0, 2) == 0);
        exec_waddr = 12'h300 + AW'($urandom_range(0, 7));
        exec_d     = DW'($urandom);
      end
      tick();
      ex_pend = exec_we && !(rst_n && !host_we);
    end
    idle();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
